// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: state encoding and
// default geometry used by the decode and write-back stages.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_N_RD     = 2;
    localparam bit DEF_ZERO_REG = 1'b1;
    localparam bit DEF_BYPASS   = 1'b1;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear engine: sweeps every entry to zero after reset or on a clr request,
// and reports ready once the whole array has been cleared.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= CLEAR;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        clr_we     = 1'b0;
        case (state_reg)
            CLEAR: begin
                clr_we = 1'b1;
                // A clr during the sweep restarts it from entry 0.
                if (clr) begin
                    ptr_next = '0;
                end else begin
                    ptr_next = ptr_reg + ADDR_W'(1);
                    if (ptr_reg == LAST) begin
                        state_next = IDLE;
                    end
                end
            end
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    assign ready    = (state_reg == IDLE);
    assign clr_addr = ptr_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: N_RD combinational read ports, two write ports
// (port 1 wins on collision), optional bypass and hard-wired zero entry.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_RD     = DEF_N_RD,
    parameter bit ZERO_REG = DEF_ZERO_REG,
    parameter bit BYPASS   = DEF_BYPASS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    output logic                   ready,
    input  logic [1:0]             w_en,
    input  logic [2*ADDR_W-1:0]    w_addr,
    input  logic [2*DATA_W-1:0]    w_data,
    input  logic [N_RD*ADDR_W-1:0] r_addr,
    output logic [N_RD*DATA_W-1:0] r_data,
    output logic                   w_conflict
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] wa [2];
    logic [DATA_W-1:0] wd [2];
    logic [1:0]        acc;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              w_conflict_reg;

    regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A write is accepted only in IDLE with no clear pending; entry 0 is
    // read-only when ZERO_REG is set.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wport
            assign wa[gi]  = w_addr[gi*ADDR_W +: ADDR_W];
            assign wd[gi]  = w_data[gi*DATA_W +: DATA_W];
            assign acc[gi] = ready & ~clr & w_en[gi] & ~(ZERO_REG && (wa[gi] == '0));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                regs[clr_addr] <= '0;
            end else begin
                if (acc[0]) regs[wa[0]] <= wd[0];
                if (acc[1]) regs[wa[1]] <= wd[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_conflict_reg <= 1'b0;
        end else begin
            w_conflict_reg <= acc[0] & acc[1] & (wa[0] == wa[1]);
        end
    end

    assign w_conflict = w_conflict_reg;

    generate
        for (genvar gi = 0; gi < N_RD; gi++) begin : g_rport
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd;

            assign ra = r_addr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                rd = regs[ra];
                if (ZERO_REG && (ra == '0)) rd = '0;
                if (BYPASS) begin
                    if (acc[0] && (wa[0] == ra)) rd = wd[0];
                    if (acc[1] && (wa[1] == ra)) rd = wd[1];
                end
                if (!ready) rd = '0;
            end

            assign r_data[gi*DATA_W +: DATA_W] = rd;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypass build and a non-bypass build share stimulus
// and are checked against a whole-array model plus a directed vector table.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [1:0]  wen;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [4:0]  ra [2];

    logic [9:0]  w_addr, r_addr;
    logic [63:0] w_data;
    logic        ready_b, ready_n, conf_b, conf_n;
    logic [63:0] rdata_b, rdata_n;

    assign w_addr = {wa[1], wa[0]};
    assign w_data = {wd[1], wd[0]};
    assign r_addr = {ra[1], ra[0]};

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready_b),
        .w_en(wen), .w_addr(w_addr), .w_data(w_data),
        .r_addr(r_addr), .r_data(rdata_b), .w_conflict(conf_b)
    );

    regfile_mp #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready_n),
        .w_en(wen), .w_addr(w_addr), .w_data(w_data),
        .r_addr(r_addr), .r_data(rdata_n), .w_conflict(conf_n)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: cleared contents plus a count of edges left in the sweep.
    logic [31:0] mem [32];
    int          remaining;
    logic        conf_m;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic bit accepted(int k);
        return (remaining == 0) && !clr && wen[k] && (wa[k] != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(logic [4:0] a, bit byp);
        if (remaining != 0) return 32'd0;
        if (a == 5'd0) return 32'd0;
        if (byp && accepted(1) && wa[1] == a) return wd[1];
        if (byp && accepted(0) && wa[0] == a) return wd[0];
        return mem[a];
    endfunction

    task automatic model_edge();
        bit c;
        c = accepted(0) && accepted(1) && (wa[0] == wa[1]);
        if (clr) begin
            remaining = 32;
            for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        end else if (remaining > 0) begin
            remaining--;
        end else begin
            if (accepted(0)) mem[wa[0]] = wd[0];
            if (accepted(1)) mem[wa[1]] = wd[1];
        end
        conf_m = c;
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic step();
        #1;
        chk("ready_byp", 32'(ready_b), 32'(remaining == 0));
        chk("ready_nb",  32'(ready_n), 32'(remaining == 0));
        chk("conf_byp",  32'(conf_b),  32'(conf_m));
        chk("conf_nb",   32'(conf_n),  32'(conf_m));
        for (int j = 0; j < 2; j++) begin
            chk("rd_byp", rdata_b[j*32 +: 32], exp_rd(ra[j], 1'b1));
            chk("rd_nb",  rdata_n[j*32 +: 32], exp_rd(ra[j], 1'b0));
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        clr = 1'b0; wen = 2'b00;
        wa[0] = 5'd0; wa[1] = 5'd0; wd[0] = 32'd0; wd[1] = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        remaining = 32;
        conf_m = 1'b0;
        #1;
        chk("rst_ready", 32'(ready_b | ready_n), 32'd0);
        chk("rst_conf",  32'(conf_b | conf_n), 32'd0);
        chk("rst_rdata", rdata_b[31:0] | rdata_b[63:32] | rdata_n[31:0], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic read_all_zero(string nm);
        for (int a = 0; a < 32; a++) begin
            ra[0] = 5'(a); ra[1] = 5'(31 - a);
            #1;
            chk(nm, rdata_b[31:0] | rdata_b[63:32] | rdata_n[31:0] | rdata_n[63:32], 32'd0);
            step();
        end
    endtask

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic [31:0] eb0, eb1, en0, en1;
        logic        econf;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0};
        tbl[1] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7, 32'h22, 32'h22, 32'h22, 32'h22, 1'b1};
        tbl[4] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0, 32'h22, 32'h0, 32'h22, 32'h0, 1'b0};
        tbl[5] = '{2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h1234, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[6] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd7, 32'h0, 32'h22, 32'h0, 32'h22, 1'b0};
        tbl[7] = '{2'b11, 5'd9, 5'd10, 32'hA5, 32'h5A, 5'd10, 5'd9, 32'h5A, 32'hA5, 32'h0, 32'h0, 1'b0};
        tbl[8] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd10, 32'hA5, 32'h5A, 32'hA5, 32'h5A, 1'b0};

        ra[0] = 5'd0; ra[1] = 5'd0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;

        // Reset and initial sweep: 32 edges with ready low.
        do_reset();
        for (int e = 0; e < 32; e++) begin
            ra[0] = 5'($urandom_range(0, 31)); ra[1] = 5'($urandom_range(0, 31));
            #1;
            chk("sweep_ready", 32'(ready_b), 32'd0);
            step();
        end
        #1;
        chk("ready_after_sweep", 32'(ready_b & ready_n), 32'd1);
        read_all_zero("init_zero");
        $display("phase reset/sweep done, %0d vectors", n_vec);

        // Directed vector table.
        for (int v = 0; v < 9; v++) begin
            wen = tbl[v].wen; wa[0] = tbl[v].wa0; wa[1] = tbl[v].wa1;
            wd[0] = tbl[v].wd0; wd[1] = tbl[v].wd1;
            ra[0] = tbl[v].ra0; ra[1] = tbl[v].ra1;
            #1;
            chk("tbl_b0", rdata_b[31:0],  tbl[v].eb0);
            chk("tbl_b1", rdata_b[63:32], tbl[v].eb1);
            chk("tbl_n0", rdata_n[31:0],  tbl[v].en0);
            chk("tbl_n1", rdata_n[63:32], tbl[v].en1);
            chk("tbl_conf", 32'(conf_b), 32'(tbl[v].econf));
            $display("vector %0d: wen=%b wa=%0d/%0d ra=%0d/%0d rd=%h/%h conf=%b",
                     v, wen, wa[0], wa[1], ra[0], ra[1], rdata_b[31:0], rdata_b[63:32], conf_b);
            step();
        end
        idle_inputs();

        // Fill 1..31, then clr with a simultaneous write to entry 3.
        for (int a = 1; a < 32; a++) begin
            wen = 2'b01; wa[0] = 5'(a); wd[0] = $urandom;
            ra[0] = 5'(a); ra[1] = 5'(a - 1);
            step();
        end
        clr = 1'b1; wen = 2'b01; wa[0] = 5'd3; wd[0] = 32'h3333_3333; ra[0] = 5'd3;
        step();
        idle_inputs();
        for (int e = 0; e < 32; e++) begin
            ra[0] = 5'd3;
            #1;
            chk("clr_ready", 32'(ready_b), 32'd0);
            step();
        end
        #1;
        chk("clr_ready_up", 32'(ready_b), 32'd1);
        read_all_zero("clr_zero");
        $display("phase clr sweep done, %0d vectors", n_vec);

        // Reset while the sweep pointer sits at 10.
        do_reset();
        repeat (10) step();
        do_reset();
        for (int e = 0; e < 32; e++) begin
            #1;
            chk("rst_mid_ready", 32'(ready_b), 32'd0);
            step();
        end
        #1;
        chk("rst_mid_ready_up", 32'(ready_b), 32'd1);
        $display("phase mid-sweep reset done, %0d vectors", n_vec);

        // Randomised traffic on a narrow address range to provoke collisions.
        for (int c = 0; c < 400; c++) begin
            clr = ($urandom_range(0, 39) == 0);
            wen = 2'($urandom_range(0, 3));
            wa[0] = 5'($urandom_range(0, 7)); wa[1] = 5'($urandom_range(0, 7));
            wd[0] = $urandom; wd[1] = $urandom;
            ra[0] = 5'($urandom_range(0, 7)); ra[1] = 5'($urandom_range(0, 31));
            step();
        end
        $display("phase random done, %0d vectors", n_vec);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the mMIPS datapath: configurable data width, depth and read-port count, two write ports with fixed priority, optional write-to-read bypass, optional hard-wired zero register, and a sequential clear engine that sweeps the array after reset or on request. It sits between decode (read ports) and write-back (write ports). It is the generalised successor of the fixed 32×32, 2-read/1-write register file.

## Interface
Parameters:
- DATA_W, 32, bits per register
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W
- N_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes
- BYPASS, 1, 1 = read of an address written this cycle returns the new data

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- clr  in  1  request a full clear sweep
- ready  out  1  high when in IDLE; writes accepted only when high
- w_en  in  2  write enables, bit k for write port k
- w_addr  in  2*ADDR_W  port k address at [k*ADDR_W +: ADDR_W]
- w_data  in  2*DATA_W  port k data at [k*DATA_W +: DATA_W]
- r_addr  in  N_RD*ADDR_W  read addresses, packed as above
- r_data  out  N_RD*DATA_W  read data, combinational from r_addr
- w_conflict  out  1  registered: both write ports hit the same address last cycle

## Operation
- FSM states: CLEAR, IDLE. Sweep pointer ptr, ADDR_W bits.
- rst_n low: state=CLEAR, ptr=0, w_conflict=0, ready=0, immediately (asynchronous). Array contents are not reset directly.
- CLEAR: each edge writes 0 to regs[ptr] and increments ptr. The edge that clears entry DEPTH-1 moves the FSM to IDLE.
- IDLE + clr: next state CLEAR, ptr=0. clr while in CLEAR restarts the sweep at ptr=0.
- Writes: only in IDLE with clr low. While clr is high or ready is low, writes are dropped, not queued.
- Port k writes w_data[k] to regs[w_addr[k]] when w_en[k]=1.
- Both ports enabled to the same address: port 1 wins, and w_conflict=1 on the next cycle. Otherwise w_conflict=0.
- ZERO_REG=1: writes to address 0 are dropped, and no conflict is flagged for that address. Reads of address 0 return 0.
- Reads: r_data[j] = regs[r_addr[j]]. While ready=0, all r_data are forced to 0.
- BYPASS=1, IDLE: if an accepted write targets r_addr[j] in the same cycle, r_data[j] = that write's w_data, with port 1 taking priority. BYPASS=0 returns the pre-edge contents.
- Width rules: addresses are unsigned. No arithmetic on data.

## Timing
- Read latency: 0 cycles, combinational. A write is visible on the non-bypassed path after the edge.
- Clear duration: exactly DEPTH edges from the first rising edge with rst_n high (or the edge sampling clr). ready rises after edge DEPTH; for DEPTH=32, writes are accepted from edge 33.
- rst_n asserted mid-sweep or mid-write: the sweep restarts from 0 after deassertion. A write on an edge coincident with reset assertion is lost.
- w_conflict is valid one cycle after the conflicting edge and lasts one cycle per conflict.
- Reset values: ready=0, w_conflict=0, r_data=0.

## Structure
- Package regfile_pkg holds the state encoding (CLEAR=1'b0, IDLE=1'b1) and default parameter constants, shared with the decode and write-back stages.
- Sub-module regfile_clear_fsm owns the state, ptr, ready and the clear-write strobe/address. The top level holds the array, write arbitration, bypass muxes and w_conflict.

## Test plan
- Reset, then idle: ready=0 for 32 edges, r_data=0 throughout; ready=1 after edge 32; all entries read 0.
- Write port 0 addr 5 = 0xDEADBEEF, read port 1 addr 5 in the same cycle: BYPASS=1 returns 0xDEADBEEF; BYPASS=0 returns 0. Next cycle returns 0xDEADBEEF in both builds.
- Both ports write addr 7 (0x11, 0x22): the entry holds 0x22, and w_conflict=1 for one cycle.
- Write addr 0 = 0xFFFF_FFFF with ZERO_REG=1: address 0 reads 0, w_conflict stays 0.
- Fill entries 1..31, pulse clr with a simultaneous write to addr 3: the write is dropped, ready=0 for 32 cycles, and all entries read 0 after.
- Assert rst_n low at sweep ptr=10, release: the sweep restarts, and ready rises 32 edges after release.
